cc_channel_sched: RTL and testbench

Round-robin grant scheduler for the five gated output channels of the `cc` control block (the channels gated by the `pm` master enable). Up to `N_REQ` requesters compete for one shared channel slot. The block issues a registered one-hot grant and bounds each tenure with a hold counter. It inserts one dead cycle between owners, so the downstream `pm`-style enable never switches directly from one owner to another.

---
 rtl/cc_sched_pkg.sv | 15 +
 rtl/cc_rr_pick.sv | 29 ++
 rtl/cc_channel_sched.sv | 89 ++++++++
 tb/tb_cc_channel_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cc_sched_pkg.sv
// Shared types and defaults for the cc channel grant scheduler.
// Owner index is fixed at 3 bits so up to 8 requesters fit.
package cc_sched_pkg;

  localparam int N_REQ_DEF    = 5;
  localparam int HOLD_MAX_DEF = 4;
  localparam int OWNER_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/cc_rr_pick.sv
// Combinational round-robin search: first set req at or after ptr, wrapping.
// Latency: 0 cycles; no backpressure (pure function of req/ptr).
module cc_rr_pick
  import cc_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               vld,
  output logic [OWNER_W-1:0] idx
);

  always_comb begin
    logic [OWNER_W-1:0] cand;
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    // Scan from the farthest offset down so the closest match to ptr wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = OWNER_W'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/cc_channel_sched.sv
// Round-robin one-hot grant for the pm-gated cc channels, hold-limited tenures, one dead cycle between owners.
// Latency: req to grant 1 cycle, all outputs registered; no backpressure, requests are levels sampled in IDLE.
module cc_channel_sched
  import cc_sched_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic               done,
  output logic [N_REQ-1:0]   grant,
  output logic [OWNER_W-1:0] owner,
  output logic               busy,
  output logic               timeout
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [OWNER_W-1:0] IDX_LAST = OWNER_W'(N_REQ - 1);

  state_e             state;
  logic [OWNER_W-1:0] ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pick_vld;
  logic [OWNER_W-1:0] pick_idx;
  logic               expire;
  logic               owner_req;
  logic               own_exit;

  cc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign expire    = (cnt == CNT_LAST);
  assign owner_req = req[owner];
  assign own_exit  = done || !owner_req || !en || expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && pick_vld) begin
            state <= ST_OWN;
            owner <= pick_idx;
            grant <= N_REQ'(1) << pick_idx;
            ptr   <= (pick_idx == IDX_LAST) ? '0 : pick_idx + OWNER_W'(1);
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_OWN: begin
          if (own_exit) begin
            state   <= ST_GAP;
            grant   <= '0;
            // Only a pure expiry counts; a coinciding release or revoke is a normal exit.
            timeout <= expire && !done && en && owner_req;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_channel_sched.sv
// Directed scenarios plus randomized traffic checked against a cycle-level tenure model.
module tb_cc_channel_sched;

  localparam int N_REQ    = 5;
  localparam int HOLD_MAX = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             en    = 1'b0;
  logic [N_REQ-1:0] req   = '0;
  logic             done  = 1'b0;
  logic [N_REQ-1:0] grant;
  logic [2:0]       owner;
  logic             busy;
  logic             timeout;

  int tests = 0;
  int fails = 0;

  // Reference model: who holds the slot, how long they have held it, whether a dead cycle is pending.
  int m_owner     = -1;
  int m_last      = N_REQ - 1;
  int m_held      = 0;
  bit m_gap       = 1'b0;
  bit m_to        = 1'b0;
  int m_owner_out = 0;

  cc_channel_sched #(.N_REQ(N_REQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  function automatic void model_step();
    int  o;
    bit  expired;
    if (reset) begin
      m_owner = -1; m_gap = 1'b0; m_last = N_REQ - 1; m_held = 0; m_to = 1'b0; m_owner_out = 0;
    end else if (m_gap) begin
      m_gap = 1'b0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      o = m_owner;
      expired = (m_held == HOLD_MAX);
      m_to = 1'b0;
      if (done || !req[o] || !en || expired) begin
        m_to = expired && !done && en && req[o];
        m_owner = -1;
        m_gap = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 1'b0;
      if (en && req != '0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int c = (m_last + k) % N_REQ;
          if (req[c]) begin
            m_owner = c; m_last = c; m_held = 1; m_owner_out = c;
            break;
          end
        end
      end
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; req = '0; done = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; req = '0; done = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    tests++; if (grant !== 5'b0)  begin fails++; $display("FAIL reset_grant got %b want 00000", grant); end
    tests++; if (owner !== 3'd0)  begin fails++; $display("FAIL reset_owner got %0d want 0", owner); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", timeout); end
  endtask

  task automatic test_single_request();
    req = 5'b00100; en = 1'b1;
    cyc();
    tests++; if (grant !== 5'b00100) begin fails++; $display("FAIL single_grant got %b want 00100", grant); end
    tests++; if (owner !== 3'd2)     begin fails++; $display("FAIL single_owner got %0d want 2", owner); end
    tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL single_busy got %b want 1", busy); end
    done = 1'b1;
    cyc();
    done = 1'b0; req = '0;
    tests++; if (grant !== 5'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
      fails++; $display("FAIL single_gap got grant=%b busy=%b to=%b want 00000/1/0", grant, busy, timeout); end
    cyc();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_o [4] = '{0, 1, 4, 0};
    do_reset();
    en = 1'b1; req = 5'b10011;
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests++; if (grant !== (5'b1 << exp_o[i]) || owner !== 3'(exp_o[i])) begin
        fails++; $display("FAIL rr_owner%0d got grant=%b owner=%0d want owner %0d", i, grant, owner, exp_o[i]); end
      done = 1'b1;
      cyc();
      done = 1'b0;
      tests++; if (grant !== 5'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL rr_gap%0d got grant=%b busy=%b want 00000/1", i, grant, busy); end
      cyc();
      tests++; if (grant !== 5'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rr_idle%0d got grant=%b busy=%b want 00000/0", i, grant, busy); end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1; req = 5'b00001;
    for (int i = 0; i < HOLD_MAX; i++) begin
      cyc();
      tests++; if (grant !== 5'b00001) begin fails++; $display("FAIL to_hold%0d got %b want 00001", i, grant); end
    end
    cyc();
    tests++; if (grant !== 5'b0 || timeout !== 1'b1) begin
      fails++; $display("FAIL to_gap got grant=%b to=%b want 00000/1", grant, timeout); end
    cyc();
    tests++; if (grant !== 5'b0 || timeout !== 1'b0) begin
      fails++; $display("FAIL to_idle got grant=%b to=%b want 00000/0", grant, timeout); end
    cyc();
    tests++; if (grant !== 5'b00001 || owner !== 3'd0) begin
      fails++; $display("FAIL to_regrant got grant=%b owner=%0d want 00001/0", grant, owner); end
  endtask

  task automatic test_done_at_expiry();
    // Continues from a fresh tenure of requester 0 (first grant cycle already seen).
    cyc(); cyc(); cyc();
    tests++; if (grant !== 5'b00001) begin fails++; $display("FAIL dx_hold got %b want 00001", grant); end
    done = 1'b1;
    cyc();
    done = 1'b0;
    tests++; if (grant !== 5'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL dx_gap got grant=%b to=%b busy=%b want 00000/0/1", grant, timeout, busy); end
    req = '0;
    cyc();
  endtask

  task automatic test_en_drop();
    en = 1'b1; req = 5'b00010;
    cyc();
    tests++; if (grant !== 5'b00010) begin fails++; $display("FAIL en_grant got %b want 00010", grant); end
    cyc();
    en = 1'b0;
    cyc();
    tests++; if (grant !== 5'b0 || timeout !== 1'b0) begin
      fails++; $display("FAIL en_revoke got grant=%b to=%b want 00000/0", grant, timeout); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests++; if (grant !== 5'b0) begin fails++; $display("FAIL en_hold%0d got %b want 00000", i, grant); end
    end
    req = '0; en = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    en = 1'b1; req = 5'b01000;
    cyc();
    tests++; if (owner !== 3'd3 || grant !== 5'b01000) begin
      fails++; $display("FAIL rst_own got owner=%0d grant=%b want 3/01000", owner, grant); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++; if (grant !== 5'b0 || owner !== 3'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_clear got grant=%b owner=%0d busy=%b want 00000/0/0", grant, owner, busy); end
    req = 5'b11111;
    cyc();
    tests++; if (grant !== 5'b00001 || owner !== 3'd0) begin
      fails++; $display("FAIL rst_regrant got grant=%b owner=%0d want 00001/0", grant, owner); end
    req = '0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] e_grant;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 7) != 0);
      req   = N_REQ'($urandom) | N_REQ'($urandom);
      done  = ($urandom_range(0, 5) == 0);
      cyc();
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      tests++; if (grant !== e_grant) begin
        fails++; $display("FAIL rand_grant cyc %0d got %b want %b", n, grant, e_grant); end
      tests++; if (owner !== 3'(m_owner_out)) begin
        fails++; $display("FAIL rand_owner cyc %0d got %0d want %0d", n, owner, m_owner_out); end
      tests++; if (busy !== ((m_owner >= 0) || m_gap)) begin
        fails++; $display("FAIL rand_busy cyc %0d got %b want %b", n, busy, (m_owner >= 0) || m_gap); end
      tests++; if (timeout !== m_to) begin
        fails++; $display("FAIL rand_timeout cyc %0d got %b want %b", n, timeout, m_to); end
    end
    reset = 1'b0; done = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_timeout();
    test_done_at_expiry();
    test_en_drop();
    test_reset_mid_tenure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
